// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//   Shared types and constants for the grid calculator keypad entry path.
//   - op_t          : operator codes driven to the ALU (ADD, SUB, MUL, AND, OR)
//   - entry_state_t : entry FSM states (OP1, OP2, EXEC, RESULT)
//   - KEY_*         : key indices on the 6-column keypad grid
//   - key_index()   : cursor position -> linear key index
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_OP1    = 2'd0,
        ST_OP2    = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESULT = 2'd3
    } entry_state_t;

    localparam int unsigned GRID_COLS = 6;

    // Digits occupy keys 0..15; decimal entry only accepts 0..9.
    localparam logic [4:0] KEY_DEC_LAST = 5'd9;
    localparam logic [4:0] KEY_HEX_LAST = 5'd15;

    localparam logic [4:0] KEY_ADD = 5'd16;
    localparam logic [4:0] KEY_SUB = 5'd17;
    localparam logic [4:0] KEY_MUL = 5'd18;
    localparam logic [4:0] KEY_AND = 5'd19;
    localparam logic [4:0] KEY_OR  = 5'd20;
    localparam logic [4:0] KEY_CE  = 5'd21;
    localparam logic [4:0] KEY_CLR = 5'd22;
    localparam logic [4:0] KEY_EXE = 5'd23;

    // Row-major linear index; max 3*6+7 = 25 fits in 5 bits.
    function automatic logic [4:0] key_index(input logic [2:0] x, input logic [1:0] y);
        return 5'(y) * 5'(GRID_COLS) + 5'(x);
    endfunction

endpackage

// File: rtl/calc_key_decoder.sv
// -----------------------------------------------------------------------------
// calc_key_decoder
//   Combinational keypad decoder: maps the cursor position to a key class.
//   Ports:
//     i_pos_x, i_pos_y : cursor column (valid 0..5) / row (0..3)
//     i_mode           : 0 = decimal (digits A..F rejected), 1 = hexadecimal
//     o_is_digit/o_digit   : digit key and its value
//     o_is_op/o_op_code    : operator key and its op_t code
//     o_is_ce, o_is_clr, o_is_exe : control keys
//     o_valid          : the position maps to a key usable in this mode
// -----------------------------------------------------------------------------
module calc_key_decoder
    import calc_pkg::*;
(
    input  logic [2:0] i_pos_x,
    input  logic [1:0] i_pos_y,
    input  logic       i_mode,
    output logic       o_is_digit,
    output logic [3:0] o_digit,
    output logic       o_is_op,
    output logic [2:0] o_op_code,
    output logic       o_is_ce,
    output logic       o_is_clr,
    output logic       o_is_exe,
    output logic       o_valid
);

    logic [4:0] w_key;
    logic [4:0] w_rel;

    assign w_key = key_index(i_pos_x, i_pos_y);
    assign w_rel = w_key - KEY_ADD;

    always_comb begin
        o_is_digit = 1'b0;
        o_digit    = '0;
        o_is_op    = 1'b0;
        o_op_code  = '0;
        o_is_ce    = 1'b0;
        o_is_clr   = 1'b0;
        o_is_exe   = 1'b0;

        // Columns 6 and 7 are off the grid and never decode to a key.
        if (i_pos_x < 3'(GRID_COLS)) begin
            if (w_key <= KEY_HEX_LAST) begin
                if (i_mode || (w_key <= KEY_DEC_LAST)) begin
                    o_is_digit = 1'b1;
                    o_digit    = w_key[3:0];
                end
            end else if (w_key <= KEY_OR) begin
                o_is_op   = 1'b1;
                o_op_code = w_rel[2:0];
            end else if (w_key == KEY_CE) begin
                o_is_ce = 1'b1;
            end else if (w_key == KEY_CLR) begin
                o_is_clr = 1'b1;
            end else if (w_key == KEY_EXE) begin
                o_is_exe = 1'b1;
            end
        end

        o_valid = o_is_digit | o_is_op | o_is_ce | o_is_clr | o_is_exe;
    end

endmodule

// File: rtl/calc_key_entry.sv
// -----------------------------------------------------------------------------
// calc_key_entry
//   Keypad entry controller for the grid calculator. Decodes cursor presses,
//   accumulates operands, sequences operand / operator / execute and hands one
//   execute request per EXE to an external combinational ALU.
//   Ports:
//     i_clk, i_rst     : clock, synchronous active-high reset
//     i_mode           : 0 = decimal entry, 1 = hexadecimal entry
//     i_press          : 1-cycle debounced key press
//     i_pos_x, i_pos_y : cursor position
//     i_alu_result     : ALU output for (o_op1, o_op2, o_op), sampled in EXEC
//     o_op1, o_op2     : latched operands
//     o_op             : operator code (0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR)
//     o_input_screen   : value being entered, or the result in RESULT
//     o_exe_valid      : high for exactly the EXEC cycle
//     o_entry_state    : current FSM state
// -----------------------------------------------------------------------------
module calc_key_entry
    import calc_pkg::*;
#(
    parameter int unsigned MAX_HEX_DIGITS = 4,
    parameter int unsigned MAX_DEC_VALUE  = 9999
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mode,
    input  logic        i_press,
    input  logic [2:0]  i_pos_x,
    input  logic [1:0]  i_pos_y,
    input  logic [15:0] i_alu_result,
    output logic [15:0] o_op1,
    output logic [15:0] o_op2,
    output logic [2:0]  o_op,
    output logic [15:0] o_input_screen,
    output logic        o_exe_valid,
    output logic [1:0]  o_entry_state
);

    // A hex append is accepted while the shifted value still fits the digit budget.
    localparam logic [20:0] HEX_LIMIT = 21'(1) << (4 * MAX_HEX_DIGITS);
    localparam logic [19:0] DEC_LIMIT = 20'(MAX_DEC_VALUE);

    entry_state_t r_state;
    logic [15:0]  r_op1;
    logic [15:0]  r_op2;
    op_t          r_op;
    logic [15:0]  r_screen;
    logic         r_exe_valid;
    logic         r_mode_q;

    logic         w_is_digit;
    logic [3:0]   w_digit;
    logic         w_is_op;
    logic [2:0]   w_op_code;
    logic         w_is_ce;
    logic         w_is_clr;
    logic         w_is_exe;
    logic         w_valid;

    logic         w_key_hit;
    logic [19:0]  w_hex_tmp;
    logic [19:0]  w_dec_tmp;
    logic         w_app_ok;
    logic [15:0]  w_app_val;
    logic         w_soft_clr;

    calc_key_decoder u_decoder (
        .i_pos_x    (i_pos_x),
        .i_pos_y    (i_pos_y),
        .i_mode     (i_mode),
        .o_is_digit (w_is_digit),
        .o_digit    (w_digit),
        .o_is_op    (w_is_op),
        .o_op_code  (w_op_code),
        .o_is_ce    (w_is_ce),
        .o_is_clr   (w_is_clr),
        .o_is_exe   (w_is_exe),
        .o_valid    (w_valid)
    );

    assign w_key_hit = i_press & w_valid;

    // Candidate next entry values; both are computed wide so no wrap can hide an overflow.
    assign w_hex_tmp = {r_screen, w_digit};
    assign w_dec_tmp = 20'(r_screen) * 20'd10 + 20'(w_digit);
    assign w_app_ok  = i_mode ? ({1'b0, w_hex_tmp} < HEX_LIMIT) : (w_dec_tmp <= DEC_LIMIT);
    assign w_app_val = i_mode ? w_hex_tmp[15:0] : w_dec_tmp[15:0];

    // Mode edge, CLR, and CE-in-RESULT all collapse to the reset image.
    // The mode edge wins over any press in the same cycle, including in EXEC.
    assign w_soft_clr = (i_mode != r_mode_q) ||
                        (w_key_hit && (r_state != ST_EXEC) &&
                         (w_is_clr || (w_is_ce && (r_state == ST_RESULT))));

    always_ff @(posedge i_clk) begin
        if (i_rst || w_soft_clr) begin
            r_state     <= ST_OP1;
            r_op1       <= '0;
            r_op2       <= '0;
            r_op        <= OP_ADD;
            r_screen    <= '0;
            r_exe_valid <= 1'b0;
            r_mode_q    <= i_mode;
        end else begin
            case (r_state)
                ST_OP1: begin
                    if (w_key_hit) begin
                        if (w_is_digit) begin
                            if (w_app_ok) begin
                                r_screen <= w_app_val;
                            end
                        end else if (w_is_op) begin
                            r_op1    <= r_screen;
                            r_op     <= op_t'(w_op_code);
                            r_screen <= '0;
                            r_state  <= ST_OP2;
                        end else if (w_is_ce) begin
                            r_screen <= '0;
                        end
                    end
                end

                ST_OP2: begin
                    if (w_key_hit) begin
                        if (w_is_digit) begin
                            if (w_app_ok) begin
                                r_screen <= w_app_val;
                            end
                        end else if (w_is_op) begin
                            r_op <= op_t'(w_op_code);
                        end else if (w_is_ce) begin
                            r_screen <= '0;
                        end else if (w_is_exe) begin
                            r_op2       <= r_screen;
                            r_exe_valid <= 1'b1;
                            r_state     <= ST_EXEC;
                        end
                    end
                end

                // Operands are stable here, so the combinational ALU output is valid.
                ST_EXEC: begin
                    r_screen    <= i_alu_result;
                    r_exe_valid <= 1'b0;
                    r_state     <= ST_RESULT;
                end

                ST_RESULT: begin
                    if (w_key_hit) begin
                        if (w_is_digit) begin
                            r_op1    <= '0;
                            r_op2    <= '0;
                            r_op     <= OP_ADD;
                            r_screen <= {12'b0, w_digit};
                            r_state  <= ST_OP1;
                        end else if (w_is_op) begin
                            r_op1    <= r_screen;
                            r_op     <= op_t'(w_op_code);
                            r_screen <= '0;
                            r_state  <= ST_OP2;
                        end
                    end
                end

                default: begin
                    r_state <= ST_OP1;
                end
            endcase
        end
    end

    assign o_op1          = r_op1;
    assign o_op2          = r_op2;
    assign o_op           = r_op;
    assign o_input_screen = r_screen;
    assign o_exe_valid    = r_exe_valid;
    assign o_entry_state  = r_state;

endmodule

// File: tb/tb_calc_key_entry.sv
// -----------------------------------------------------------------------------
// tb_calc_key_entry
//   Directed bench for calc_key_entry. Each step drives one cycle of stimulus,
//   pushes the expected output image to a scoreboard queue, and compares it
//   against the DUT one cycle later.
// -----------------------------------------------------------------------------
module tb_calc_key_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        press;
    logic [2:0]  pos_x;
    logic [1:0]  pos_y;
    logic [15:0] alu_result;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  op;
    logic [15:0] input_screen;
    logic        exe_valid;
    logic [1:0]  entry_state;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  op;
        logic [15:0] scr;
        logic        ev;
        logic [1:0]  st;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];

    always #5 clk = ~clk;

    calc_key_entry #(
        .MAX_HEX_DIGITS (4),
        .MAX_DEC_VALUE  (9999)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mode         (mode),
        .i_press        (press),
        .i_pos_x        (pos_x),
        .i_pos_y        (pos_y),
        .i_alu_result   (alu_result),
        .o_op1          (op1),
        .o_op2          (op2),
        .o_op           (op),
        .o_input_screen (input_screen),
        .o_exe_valid    (exe_valid),
        .o_entry_state  (entry_state)
    );

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                                input logic [15:0] s, input logic ev, input logic [1:0] st);
        exp_t e;
        e.op1 = a;
        e.op2 = b;
        e.op  = o;
        e.scr = s;
        e.ev  = ev;
        e.st  = st;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out();
        exp_t  e;
        string t;
        checks++;
        assert (sbq.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", sbq.size());
            return;
        end
        e = sbq.pop_front();
        t = tagq.pop_front();
        chk({t, ".op1"},   op1,                  e.op1);
        chk({t, ".op2"},   op2,                  e.op2);
        chk({t, ".op"},    {13'b0, op},          {13'b0, e.op});
        chk({t, ".scr"},   input_screen,         e.scr);
        chk({t, ".exe"},   {15'b0, exe_valid},   {15'b0, e.ev});
        chk({t, ".state"}, {14'b0, entry_state}, {14'b0, e.st});
    endtask

    // Inputs change 1 time unit after a rising edge, so they are sampled on the next edge.
    task automatic step_xy(input string tag, input logic pr, input logic [2:0] x,
                           input logic [1:0] y, input exp_t e);
        pos_x = x;
        pos_y = y;
        press = pr;
        sbq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        press = 1'b0;
        compare_out();
    endtask

    task automatic key(input string tag, input int k, input exp_t e);
        step_xy(tag, 1'b1, 3'(k % 6), 2'(k / 6), e);
    endtask

    task automatic idle(input string tag, input exp_t e);
        step_xy(tag, 1'b0, 3'd0, 2'd0, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t z;
        z = mk(16'd0, 16'd0, 3'd0, 16'd0, 1'b0, 2'd0);

        rst = 1'b1; mode = 1'b1; press = 1'b0; pos_x = '0; pos_y = '0; alu_result = '0;
        @(posedge clk);
        #1;
        idle("reset", z);
        rst = 1'b0;

        // Hex entry: fifth digit does not fit in 16 bits
        key("hex1", 1, mk(0, 0, 0, 16'h0001, 0, 0));
        key("hex2", 2, mk(0, 0, 0, 16'h0012, 0, 0));
        key("hex3", 3, mk(0, 0, 0, 16'h0123, 0, 0));
        key("hex4", 4, mk(0, 0, 0, 16'h1234, 0, 0));
        key("hex5_ignored", 5, mk(0, 0, 0, 16'h1234, 0, 0));
        key("clr", 22, z);
        key("hexF", 15, mk(0, 0, 0, 16'h000F, 0, 0));

        // Mode edge alone clears
        mode = 1'b0;
        idle("mode_to_dec", z);

        // Decimal 12 + 34 = 46
        alu_result = 16'd46;
        key("d1", 1, mk(0, 0, 0, 16'd1, 0, 0));
        key("d12", 2, mk(0, 0, 0, 16'd12, 0, 0));
        key("add", 16, mk(16'd12, 0, 0, 0, 0, 1));
        key("d3", 3, mk(16'd12, 0, 0, 16'd3, 0, 1));
        key("d34", 4, mk(16'd12, 0, 0, 16'd34, 0, 1));
        key("exe", 23, mk(16'd12, 16'd34, 0, 16'd34, 1, 2));
        idle("result", mk(16'd12, 16'd34, 0, 16'd46, 0, 3));
        idle("result_hold", mk(16'd12, 16'd34, 0, 16'd46, 0, 3));

        // Chaining from the result
        key("chain_sub", 17, mk(16'd46, 16'd34, 1, 0, 0, 1));
        key("chain_d7", 7, mk(16'd46, 16'd34, 1, 16'd7, 0, 1));
        alu_result = 16'd39;
        key("chain_exe", 23, mk(16'd46, 16'd7, 1, 16'd7, 1, 2));
        idle("chain_result", mk(16'd46, 16'd7, 1, 16'd39, 0, 3));
        key("result_exe_ignored", 23, mk(16'd46, 16'd7, 1, 16'd39, 0, 3));

        // Digit in RESULT starts a fresh calculation
        key("result_digit", 8, mk(0, 0, 0, 16'd8, 0, 0));

        // Operator replacement and CE in OP2
        key("op2_add", 16, mk(16'd8, 0, 0, 0, 0, 1));
        key("op2_d5", 5, mk(16'd8, 0, 0, 16'd5, 0, 1));
        key("op2_mul", 18, mk(16'd8, 0, 2, 16'd5, 0, 1));
        key("op2_and", 19, mk(16'd8, 0, 3, 16'd5, 0, 1));
        key("op2_or", 20, mk(16'd8, 0, 4, 16'd5, 0, 1));
        key("op2_ce", 21, mk(16'd8, 0, 4, 0, 0, 1));
        key("clr2", 22, z);

        // EXE ignored in OP1, CE clears entry
        key("op1_d9", 9, mk(0, 0, 0, 16'd9, 0, 0));
        key("op1_exe_ignored", 23, mk(0, 0, 0, 16'd9, 0, 0));
        key("op1_ce", 21, z);

        // Decimal limit
        key("lim9", 9, mk(0, 0, 0, 16'd9, 0, 0));
        key("lim99", 9, mk(0, 0, 0, 16'd99, 0, 0));
        key("lim999", 9, mk(0, 0, 0, 16'd999, 0, 0));
        key("lim9999", 9, mk(0, 0, 0, 16'd9999, 0, 0));
        key("lim_d5_ignored", 5, mk(0, 0, 0, 16'd9999, 0, 0));
        key("dec_A_ignored", 10, mk(0, 0, 0, 16'd9999, 0, 0));

        // Mode edge together with a digit press: cleared, digit dropped
        mode = 1'b1;
        key("mode_edge_press", 5, z);

        // Press during EXEC is dropped; CE in RESULT acts as CLR
        key("x_d2", 2, mk(0, 0, 0, 16'd2, 0, 0));
        key("x_add", 16, mk(16'd2, 0, 0, 0, 0, 1));
        key("x_d3", 3, mk(16'd2, 0, 0, 16'd3, 0, 1));
        alu_result = 16'd5;
        key("x_exe", 23, mk(16'd2, 16'd3, 0, 16'd3, 1, 2));
        key("exec_press_dropped", 9, mk(16'd2, 16'd3, 0, 16'd5, 0, 3));
        key("result_ce_clr", 21, z);

        // Reset asserted during EXEC
        key("r_d1", 1, mk(0, 0, 0, 16'd1, 0, 0));
        key("r_add", 16, mk(16'd1, 0, 0, 0, 0, 1));
        key("r_d2", 2, mk(16'd1, 0, 0, 16'd2, 0, 1));
        key("r_exe", 23, mk(16'd1, 16'd2, 0, 16'd2, 1, 2));
        rst = 1'b1;
        idle("rst_in_exec", z);
        rst = 1'b0;

        // Off-grid columns ignored
        key("p_d1", 1, mk(0, 0, 0, 16'd1, 0, 0));
        step_xy("posx6", 1'b1, 3'd6, 2'd0, mk(0, 0, 0, 16'd1, 0, 0));
        step_xy("posx7", 1'b1, 3'd7, 2'd3, mk(0, 0, 0, 16'd1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
